// File: rtl/viterbi_depuncture_decoder.sv
// Hard-decision register-exchange Viterbi decoder, K=7 rate-1/2 (133o/171o),
// with per-bit erasure masks for punctured streams. Decision is the oldest survivor bit of state 0.
module viterbi_depuncture_decoder #(
    parameter int TB_DEPTH = 48,
    parameter int PM_W     = 8
) (
    input  logic       Clk,
    input  logic       reset,
    input  logic [1:0] AB,
    input  logic [1:0] valid_in,
    output logic       out,
    output logic       valid_out
);

    localparam int NS    = 64;
    localparam int CNT_W = $clog2(TB_DEPTH + 1);

    logic [PM_W-1:0]     pm_reg    [NS];
    logic [PM_W-1:0]     pm_next   [NS];
    logic [TB_DEPTH-1:0] surv_reg  [NS];
    logic [TB_DEPTH-1:0] surv_next [NS];
    logic [CNT_W-1:0]    cnt_reg;
    logic                step;

    assign step = |valid_in;

    // Hamming distance between the received pair and the branch label; erased bits contribute 0.
    function automatic logic [1:0] branch_metric(
        input logic [5:0] p,
        input logic       u,
        input logic [1:0] ab,
        input logic [1:0] vm
    );
        logic a;
        logic b;
        a = u ^ p[4] ^ p[3] ^ p[1] ^ p[0];
        b = u ^ p[5] ^ p[4] ^ p[3] ^ p[0];
        return {1'b0, vm[1] & (ab[1] ^ a)} + {1'b0, vm[0] & (ab[0] ^ b)};
    endfunction

    generate
        for (genvar gi = 0; gi < NS; gi++) begin : g_acs
            localparam logic [5:0] N  = 6'(gi);
            localparam logic [5:0] P0 = {N[4:0], 1'b0};
            localparam logic [5:0] P1 = {N[4:0], 1'b1};
            localparam logic       U  = N[5];

            logic [1:0]      bm0;
            logic [1:0]      bm1;
            logic [PM_W-1:0] m0;
            logic [PM_W-1:0] m1;
            logic [PM_W-1:0] diff;
            logic            sel;

            assign bm0  = branch_metric(P0, U, AB, valid_in);
            assign bm1  = branch_metric(P1, U, AB, valid_in);
            assign m0   = pm_reg[P0] + PM_W'(bm0);
            assign m1   = pm_reg[P1] + PM_W'(bm1);
            // Wrap-around compare: P1 wins only when m0-m1 is strictly positive as a signed value.
            assign diff = m0 - m1;
            assign sel  = ~diff[PM_W-1] && (diff != '0);

            assign pm_next[gi]   = sel ? m1 : m0;
            assign surv_next[gi] = sel ? {surv_reg[P1][TB_DEPTH-2:0], U}
                                       : {surv_reg[P0][TB_DEPTH-2:0], U};
        end
    endgenerate

    always_ff @(posedge Clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NS; i++) begin
                pm_reg[i]   <= (i == 0) ? '0 : PM_W'(32);
                surv_reg[i] <= '0;
            end
            cnt_reg   <= '0;
            out       <= 1'b0;
            valid_out <= 1'b0;
        end else if (step) begin
            for (int i = 0; i < NS; i++) begin
                pm_reg[i]   <= pm_next[i];
                surv_reg[i] <= surv_next[i];
            end
            if (cnt_reg < CNT_W'(TB_DEPTH)) begin
                cnt_reg <= cnt_reg + 1'b1;
            end
            out       <= surv_next[0][TB_DEPTH-1];
            valid_out <= (cnt_reg >= CNT_W'(TB_DEPTH - 1));
        end else begin
            valid_out <= 1'b0;
        end
    end

endmodule

// File: tb/tb_viterbi_depuncture_decoder.sv
// Bench for viterbi_depuncture_decoder: encodes random/PRBS streams with a delay-line encoder and
// expects the information bits back after the fixed decode latency.
module tb_viterbi_depuncture_decoder;

    localparam int TBD = 48;

    logic       Clk = 1'b0;
    logic       reset;
    logic [1:0] AB;
    logic [1:0] valid_in;
    logic       out;
    logic       valid_out;

    always #5 Clk = ~Clk;

    viterbi_depuncture_decoder #(.TB_DEPTH(TBD), .PM_W(8)) dut (
        .Clk       (Clk),
        .reset     (reset),
        .AB        (AB),
        .valid_in  (valid_in),
        .out       (out),
        .valid_out (valid_out)
    );

    int         n_vec = 0;
    int         n_err = 0;
    int         tot;          // steps since last reset
    bit         info_q[$];    // information bits in step order
    logic [6:0] enc_w;        // enc_w[d] = information bit d steps ago (d=0 current)
    logic [6:0] prbs;

    task automatic check(input string tag, input logic obs, input logic exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %b expected %b (step %0d)", tag, obs, exp, tot);
        end
    endtask

    task automatic model_reset();
        tot   = 0;
        info_q.delete();
        enc_w = '0;
    endtask

    task automatic do_step(input logic [1:0] ab, input logic [1:0] m, input string tag);
        logic exp_vo;
        AB       = ab;
        valid_in = m;
        @(posedge Clk);
        #1;
        if (m != 2'b00) tot++;
        exp_vo = (m != 2'b00) && (tot >= TBD);
        check({tag, "_valid"}, valid_out, exp_vo);
        if (exp_vo) check({tag, "_out"}, out, info_q[tot - TBD]);
    endtask

    task automatic bubble(input string tag);
        do_step(2'($urandom), 2'b00, tag);
    endtask

    task automatic send_bit(input bit u, input logic [1:0] m, input logic [1:0] flip, input string tag);
        logic a;
        logic b;
        logic [1:0] ab;
        enc_w = {enc_w[5:0], u};
        a  = enc_w[0] ^ enc_w[2] ^ enc_w[3] ^ enc_w[5] ^ enc_w[6];   // 133o
        b  = enc_w[0] ^ enc_w[1] ^ enc_w[2] ^ enc_w[3] ^ enc_w[6];   // 171o
        ab = {a, b} ^ flip;
        if (!m[1]) ab[1] = 1'($urandom);
        if (!m[0]) ab[0] = 1'($urandom);
        info_q.push_back(u);
        do_step(ab, m, tag);
    endtask

    function automatic bit prbs_next();
        prbs = {prbs[5:0], prbs[6] ^ prbs[5]};
        return prbs[0];
    endfunction

    task automatic prbs_seed();
        prbs = 7'($urandom_range(1, 127));
    endtask

    task automatic pulse_reset(input string tag);
        reset = 1'b0;
        #1;
        check({tag, "_rst_out"}, out, 1'b0);
        check({tag, "_rst_valid"}, valid_out, 1'b0);
        #2;
        reset = 1'b1;
        model_reset();
    endtask

    function automatic logic [1:0] punct_mask(input int i);
        logic [1:0] pat [3];
        pat[0] = 2'b11;
        pat[1] = 2'b10;
        pat[2] = 2'b01;
        return (i < 24) ? 2'b11 : pat[(i - 24) % 3];
    endfunction

    int flip_at [5];
    int fi;

    initial begin
        reset    = 1'b0;
        AB       = 2'b00;
        valid_in = 2'b00;
        model_reset();
        #12;
        check("reset_out", out, 1'b0);
        check("reset_valid", valid_out, 1'b0);
        @(negedge Clk);
        reset = 1'b1;
        bubble("idle");
        bubble("idle");

        // T1: all-zero stream
        for (int i = 0; i < 100; i++) send_bit(1'b0, 2'b11, 2'b00, "t1");

        // T2: clean rate 1/2, PRBS-7, flushed with encoded zeros
        pulse_reset("t2");
        prbs_seed();
        for (int i = 0; i < 200; i++) send_bit(prbs_next(), 2'b11, 2'b00, "t2");
        for (int i = 0; i < TBD - 1; i++) send_bit(1'b0, 2'b11, 2'b00, "t2f");

        // T3: five isolated single-bit channel errors
        pulse_reset("t3");
        prbs_seed();
        for (int j = 0; j < 5; j++) flip_at[j] = 30 + 30 * j + $urandom_range(0, 9);
        fi = 0;
        for (int i = 0; i < 200; i++) begin
            if (fi < 5 && i == flip_at[fi]) begin
                send_bit(prbs_next(), 2'b11, 2'b01 << $urandom_range(0, 1), "t3");
                fi++;
            end else begin
                send_bit(prbs_next(), 2'b11, 2'b00, "t3");
            end
        end
        for (int i = 0; i < TBD - 1; i++) send_bit(1'b0, 2'b11, 2'b00, "t3f");

        // T4: rate 3/4 puncturing after step 24, erased bits driven with garbage
        pulse_reset("t4");
        for (int i = 0; i < 200; i++) send_bit(1'($urandom), punct_mask(i), 2'b00, "t4");
        for (int i = 200; i < 200 + TBD - 1; i++) send_bit(1'b0, punct_mask(i), 2'b00, "t4f");

        // T5: random idle bubbles between steps
        pulse_reset("t5");
        prbs_seed();
        for (int i = 0; i < 200; i++) begin
            if ($urandom_range(0, 5) == 0) begin
                for (int k = 0; k < int'($urandom_range(1, 3)); k++) bubble("t5_bubble");
            end
            send_bit(prbs_next(), 2'b11, 2'b00, "t5");
        end
        for (int i = 0; i < TBD - 1; i++) send_bit(1'b0, 2'b11, 2'b00, "t5f");

        // T6: reset mid-stream, then restart
        pulse_reset("t6");
        prbs_seed();
        for (int i = 0; i < 100; i++) send_bit(prbs_next(), 2'b11, 2'b00, "t6");
        check("t6_pre_valid", valid_out, 1'b1);
        pulse_reset("t6_mid");
        for (int i = 0; i < 120; i++) send_bit(1'($urandom), 2'b11, 2'b00, "t6r");
        for (int i = 0; i < TBD - 1; i++) send_bit(1'b0, 2'b11, 2'b00, "t6rf");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
